// File: rtl/i2s_multi_capture.sv
`default_nettype none
// i2s_multi_capture: I2S master for NUM_LINES stereo lines with channel mask, frame
// decimation and truncation, serialising kept frames MSB-byte-first onto a valid/ready stream.
module i2s_multi_capture #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int I2S_CLK_FREQ  = 1_500_000,
    parameter int NUM_LINES     = 2,
    parameter int SLOT_BITS     = 32,
    parameter int DATA_SIZE     = 24,
    parameter int OUT_BYTES     = 2,
    parameter int REDUCE_FACTOR = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [2*NUM_LINES-1:0] chan_mask,
    output logic                   i2s_clk,
    output logic                   i2s_ws,
    input  logic [NUM_LINES-1:0]   i2s_sd,
    output logic [7:0]             byte_data,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   frame_start,
    output logic                   overflow,
    output logic [15:0]            drop_count
);

    localparam int DIV_RAW = CLK_FREQ / (2 * I2S_CLK_FREQ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NCH     = 2 * NUM_LINES;
    localparam int CW      = $clog2(NCH);
    localparam int SBW     = $clog2(SLOT_BITS);
    localparam int TB      = OUT_BYTES * 8;
    localparam int BW      = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
    localparam int FW      = (REDUCE_FACTOR > 1) ? $clog2(REDUCE_FACTOR) : 1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    logic [DW-1:0]                r_div;
    logic                         r_i2s_clk;
    logic                         r_ws;
    logic [SBW-1:0]               r_bit;
    logic [FW-1:0]                r_frame;
    logic [NCH-1:0][DATA_SIZE-1:0] r_sh;
    logic [NCH-1:0][DATA_SIZE-1:0] w_sh_next;
    logic [NCH-1:0][TB-1:0]       w_snap_next;
    logic [NCH-1:0][TB-1:0]       r_snap;
    logic                         w_tick;
    logic                         w_rise;
    logic                         w_fall;
    logic                         w_data_bit;
    logic                         w_decide;
    logic                         w_keep;

    state_t                       r_state;
    state_t                       w_state_next;
    logic [NCH-1:0]               r_mask;
    logic [CW-1:0]                r_ch;
    logic [CW-1:0]                w_first_ch;
    logic [CW-1:0]                w_next_ch;
    logic                         w_has_next;
    logic [BW-1:0]                r_byte;
    logic                         r_first;
    logic                         r_overflow;
    logic [15:0]                  r_drops;
    logic                         w_valid;
    logic                         w_xfer;
    logic                         w_last_byte;
    logic                         w_load;
    logic                         w_drop;
    logic                         w_done;
    logic [TB-1:0]                w_sample;
    logic [7:0]                   w_byte;

    assign w_tick     = enable && (r_div == DW'(DIV - 1));
    assign w_rise     = w_tick && !r_i2s_clk;
    assign w_fall     = w_tick && r_i2s_clk;
    assign w_data_bit = (r_bit >= SBW'(1)) && (r_bit <= SBW'(DATA_SIZE));
    assign w_decide   = w_rise && r_ws && (r_bit == SBW'(SLOT_BITS - 1));
    assign w_keep     = w_decide && (r_frame == '0);

    // Only the shift register of the slot currently on the bus moves.
    always_comb begin
        w_sh_next = r_sh;
        if (w_data_bit) begin
            for (int l = 0; l < NUM_LINES; l++) begin
                for (int c = 0; c < 2; c++) begin
                    if (r_ws == 1'(c)) begin
                        w_sh_next[2*l+c] = {r_sh[2*l+c][DATA_SIZE-2:0], i2s_sd[l]};
                    end
                end
            end
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            if (TB > DATA_SIZE) begin : g_pad
                assign w_snap_next[c] = {w_sh_next[c], {(TB - DATA_SIZE){1'b0}}};
            end else if (TB == DATA_SIZE) begin : g_exact
                assign w_snap_next[c] = w_sh_next[c];
            end else begin : g_cut
                assign w_snap_next[c] = w_sh_next[c][DATA_SIZE-1 -: TB];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_i2s_clk <= 1'b0;
            r_ws      <= 1'b0;
            r_bit     <= '0;
            r_frame   <= '0;
            r_sh      <= '0;
        end else if (!enable) begin
            r_div     <= '0;
            r_i2s_clk <= 1'b0;
            r_ws      <= 1'b0;
            r_bit     <= '0;
            r_frame   <= '0;
        end else begin
            if (w_tick) begin
                r_div     <= '0;
                r_i2s_clk <= ~r_i2s_clk;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_rise) begin
                r_sh <= w_sh_next;
            end
            if (w_fall) begin
                if (r_bit == SBW'(SLOT_BITS - 1)) begin
                    r_bit <= '0;
                    r_ws  <= ~r_ws;
                end else begin
                    r_bit <= r_bit + 1'b1;
                end
            end
            if (w_decide) begin
                r_frame <= (r_frame == FW'(REDUCE_FACTOR - 1)) ? '0 : r_frame + 1'b1;
            end
        end
    end

    assign w_valid     = (r_state == S_SEND);
    assign w_xfer      = w_valid && byte_ready;
    assign w_last_byte = (r_byte == BW'(OUT_BYTES - 1));
    // A kept frame landing while a frame is still in flight (even on its last byte) is dropped.
    assign w_load      = w_keep && (|chan_mask) && (r_state == S_IDLE);
    assign w_drop      = w_keep && (|chan_mask) && (r_state == S_SEND);
    assign w_done      = w_xfer && w_last_byte && !w_has_next;

    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_has_next = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) begin
                w_first_ch = CW'(i);
            end
            if (r_mask[i] && (CW'(i) > r_ch)) begin
                w_has_next = 1'b1;
                w_next_ch  = CW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_load) w_state_next = S_SEND;
            S_SEND: if (w_done) w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_mask     <= '0;
            r_ch       <= '0;
            r_byte     <= '0;
            r_first    <= 1'b0;
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else begin
            if (w_load) begin
                r_snap  <= w_snap_next;
                r_mask  <= chan_mask;
                r_ch    <= w_first_ch;
                r_byte  <= '0;
                r_first <= 1'b1;
            end else if (w_xfer) begin
                r_first <= 1'b0;
                if (w_last_byte) begin
                    r_byte <= '0;
                    r_ch   <= w_next_ch;
                end else begin
                    r_byte <= r_byte + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drops != 16'hFFFF) begin
                    r_drops <= r_drops + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_sample = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_ch == CW'(c)) w_sample = r_snap[c];
        end
    end

    always_comb begin
        w_byte = '0;
        for (int b = 0; b < OUT_BYTES; b++) begin
            if (r_byte == BW'(OUT_BYTES - 1 - b)) w_byte = w_sample[b*8 +: 8];
        end
    end

    assign i2s_clk     = r_i2s_clk;
    assign i2s_ws      = r_ws;
    assign byte_valid  = w_valid;
    assign byte_data   = w_valid ? w_byte : 8'h00;
    assign frame_start = w_valid && r_first;
    assign overflow    = r_overflow;
    assign drop_count  = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_i2s_multi_capture.sv
`default_nettype none
// tb_i2s_multi_capture: random I2S slave + frame-level reference model feeding a byte
// scoreboard; a monitor pops and compares every accepted byte.
module tb_i2s_multi_capture;

    localparam int CLK_FREQ = 8_000_000;
    localparam int I2S_FREQ = 1_000_000;
    localparam int NL       = 2;
    localparam int SB       = 32;
    localparam int DS       = 24;
    localparam int OB       = 4;
    localparam int RF       = 2;
    localparam int DIV      = CLK_FREQ / (2 * I2S_FREQ);
    localparam int NCH      = 2 * NL;
    localparam int FRAME_CYC = 2 * SB * 2 * DIV;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            enable = 1'b0;
    logic [NCH-1:0]  chan_mask = '0;
    logic            i2s_clk;
    logic            i2s_ws;
    logic [NL-1:0]   i2s_sd = '0;
    logic [7:0]      byte_data;
    logic            byte_valid;
    logic            byte_ready = 1'b0;
    logic            frame_start;
    logic            overflow;
    logic [15:0]     drop_count;

    i2s_multi_capture #(
        .CLK_FREQ(CLK_FREQ), .I2S_CLK_FREQ(I2S_FREQ), .NUM_LINES(NL), .SLOT_BITS(SB),
        .DATA_SIZE(DS), .OUT_BYTES(OB), .REDUCE_FACTOR(RF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .chan_mask(chan_mask),
        .i2s_clk(i2s_clk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .frame_start(frame_start), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       first;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    exp_t       e;
    int         exp_drops = 0;
    int         p = 0;
    int         frames_done = 0;
    int         ready_pct = 100;
    int         xfer_count = 0;
    int         cyc = 0;
    int         lastrise = -1;
    logic [DS-1:0] samp [NCH];
    logic [7:0] prev_data = '0;
    logic       prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic new_samples();
        for (int c = 0; c < NCH; c++) samp[c] = DS'($urandom);
    endtask

    // Slot bit 0 is the delay bit; bits 1..DS carry the sample MSB first, the rest is noise.
    task automatic drive_bits();
        int b, slot;
        b    = p % SB;
        slot = (p / SB) % 2;
        for (int l = 0; l < NL; l++) begin
            if (b >= 1 && b <= DS) i2s_sd[l] = samp[2*l+slot][DS-b];
            else                   i2s_sd[l] = 1'($urandom);
        end
    endtask

    task automatic model_frame(input int f);
        logic [31:0] full;
        logic        first;
        frames_done++;
        if ((f % RF) == 0 && chan_mask != '0) begin
            if (exp_q.size() > 0) begin
                exp_drops++;
            end else begin
                first = 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    if (chan_mask[c]) begin
                        full = 32'(samp[c]) << (32 - DS);
                        for (int k = 0; k < OB; k++) begin
                            exp_q.push_back({full[31-8*k -: 8], first});
                            first = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        byte_ready = ($urandom_range(99) < ready_pct);
    end

    always @(negedge i2s_clk) begin
        if (enable) begin
            p++;
            if (p % (2 * SB) == 0) new_samples();
            drive_bits();
            #1;
            check("ws_phase", {31'b0, i2s_ws}, 32'((p / SB) % 2));
        end
    end

    always @(posedge i2s_clk) begin
        if (enable) begin
            if (lastrise >= 0) check("i2s_clk_period", 32'(cyc - lastrise), 32'(2 * DIV));
            lastrise = cyc;
            if (p % (2 * SB) == 2 * SB - 1) model_frame(p / (2 * SB));
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, byte_valid}, 32'd1);
                check("hold_data", {24'b0, byte_data}, {24'b0, prev_data});
            end
            if (byte_valid && byte_ready) begin
                xfer_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte actual=%0h required=none", byte_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", {24'b0, byte_data}, {24'b0, e.data});
                    check("frame_start", {31'b0, frame_start}, {31'b0, e.first});
                end
            end
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
        end
    end

    task automatic start_enable();
        @(posedge clk);
        #1;
        p        = 0;
        lastrise = -1;
        new_samples();
        drive_bits();
        enable = 1'b1;
    endtask

    task automatic stop_enable();
        @(posedge clk);
        #1;
        enable   = 1'b0;
        lastrise = -1;
    endtask

    task automatic run_frames(input int n);
        int target, budget;
        target = frames_done + n;
        budget = (n + 1) * FRAME_CYC;
        while (frames_done < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("frame_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 4000;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i2s_clk"}, {31'b0, i2s_clk}, 32'd0);
        check({tag, "_ws"}, {31'b0, i2s_ws}, 32'd0);
        check({tag, "_byte_data"}, {24'b0, byte_data}, 32'd0);
        check({tag, "_byte_valid"}, {31'b0, byte_valid}, 32'd0);
        check({tag, "_frame_start"}, {31'b0, frame_start}, 32'd0);
        check({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
        check({tag, "_drop_count"}, {16'b0, drop_count}, 32'd0);
    endtask

    initial begin
        logic [NCH-1:0] masks [4];
        int             seen;
        int             budget;
        masks = '{4'b0101, 4'b1000, 4'b0000, 4'b0110};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // All channels, mild backpressure, decimation by RF.
        chan_mask = 4'b1111;
        ready_pct = 80;
        start_enable();
        run_frames(6);
        stop_enable();
        drain();

        // Mask patterns, each starting a fresh enable run (frame 0 kept).
        foreach (masks[i]) begin
            chan_mask = masks[i];
            start_enable();
            run_frames(3);
            stop_enable();
            drain();
        end
        check("overflow_clean", {31'b0, overflow}, 32'd0);
        check("drops_clean", {16'b0, drop_count}, 32'd0);

        // Enable dropped mid-Right slot: the frame must never be emitted.
        chan_mask = 4'b1111;
        ready_pct = 100;
        seen = xfer_count;
        start_enable();
        budget = FRAME_CYC;
        while (p < SB + SB / 2 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("mid_slot_timeout", 32'(p >= SB + SB / 2), 32'd1);
        stop_enable();
        repeat (200) @(posedge clk);
        check("aborted_frame_bytes", 32'(xfer_count - seen), 32'd0);
        start_enable();
        run_frames(1);
        stop_enable();
        drain();

        // Stalled sink across two kept frames: second dropped, first resumes intact.
        ready_pct = 0;
        repeat (2) @(posedge clk);
        start_enable();
        run_frames(3);
        #1;
        check("ovf_flag", {31'b0, overflow}, 32'(exp_drops > 0));
        check("ovf_count", {16'b0, drop_count}, 32'(exp_drops));
        check("ovf_count_one", {16'b0, drop_count}, 32'd1);
        check("ovf_valid_held", {31'b0, byte_valid}, 32'd1);
        check("ovf_first_flag", {31'b0, frame_start}, 32'd1);
        if (exp_q.size() > 0) check("ovf_first_byte", {24'b0, byte_data}, {24'b0, exp_q[0].data});
        ready_pct = 100;
        run_frames(2);
        stop_enable();
        drain();
        check("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Asynchronous reset in the middle of a stalled frame.
        ready_pct = 0;
        start_enable();
        run_frames(1);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        exp_drops = 0;
        enable    = 1'b0;
        ready_pct = 100;
        seen      = xfer_count;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge clk);
        check("post_rst_bytes", 32'(xfer_count - seen), 32'd0);
        check("post_rst_valid", {31'b0, byte_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
